// File: rtl/servo_pwm_multi.sv
// N-channel RC-servo pulse generator with per-channel enables, clamped widths and
// updates that take effect only at frame boundaries. Optional macro: SERVO_SLEW_LIMIT_EN.
module servo_pwm_multi #(
    parameter int NUM_CH      = 2,
    parameter int VALUE_W     = 8,
    parameter int CLK_DIV     = 16,
    parameter int PERIOD_CNT  = 23040,
    parameter int MIN_CNT     = 1152,
    parameter int MAX_CNT     = 2304,
    parameter int MID_CNT     = 1728,
    parameter int SCALE_SHIFT = 3,
    parameter int SLEW_STEP   = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [NUM_CH*VALUE_W-1:0] value_i,
    input  logic                      load_i,
    input  logic [NUM_CH-1:0]         enable_i,
    output logic [NUM_CH-1:0]         servo_pulse_o,
    output logic                      frame_start_o,
    output logic                      pending_o
);

    localparam int CNT_W = $clog2(PERIOD_CNT);
    localparam int DIV_W = $clog2(CLK_DIV);
    // Wide enough that a large value cannot wrap before the clamp sees it.
    localparam int SUM_W = (CNT_W + 1 > VALUE_W + SCALE_SHIFT + 1) ? CNT_W + 1
                                                                   : VALUE_W + SCALE_SHIFT + 1;

    if (MAX_CNT >= PERIOD_CNT) begin : g_bad_max
        $error("servo_pwm_multi: MAX_CNT must be less than PERIOD_CNT");
    end
    if (CLK_DIV < 2 || SLEW_STEP < 1 || MIN_CNT > MAX_CNT) begin : g_bad_cfg
        $error("servo_pwm_multi: invalid CLK_DIV, SLEW_STEP or MIN_CNT");
    end

    logic [DIV_W-1:0]   presc;
    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic               boundary;
    logic [VALUE_W-1:0] stg_val  [NUM_CH];
    logic [NUM_CH-1:0]  stg_en;
    logic [SUM_W-1:0]   sum      [NUM_CH];
    logic [CNT_W-1:0]   tgt_calc [NUM_CH];
    logic [CNT_W-1:0]   act_w    [NUM_CH];
    logic [NUM_CH-1:0]  act_en;

    assign tick     = (presc == DIV_W'(CLK_DIV - 1));
    assign boundary = tick && (cnt == CNT_W'(PERIOD_CNT - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == CNT_W'(PERIOD_CNT - 1)) ? '0 : cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                stg_val[k] <= '0;
            end
            stg_en    <= '0;
            pending_o <= 1'b0;
        end else if (load_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                stg_val[k] <= value_i[k*VALUE_W +: VALUE_W];
            end
            stg_en    <= enable_i;
            pending_o <= 1'b1;
        end else if (boundary) begin
            pending_o <= 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k]      = SUM_W'(MIN_CNT) + (SUM_W'(stg_val[k]) << SCALE_SHIFT);
            tgt_calc[k] = (sum[k] > SUM_W'(MAX_CNT)) ? CNT_W'(MAX_CNT) : sum[k][CNT_W-1:0];
        end
    end

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SLEW_STEP);

    logic [CNT_W-1:0] tgt       [NUM_CH];
    logic [CNT_W-1:0] goal      [NUM_CH];
    logic [CNT_W-1:0] slew_next [NUM_CH];

    // A fresh commit retargets immediately, so the first step already heads toward it.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            goal[k] = pending_o ? tgt_calc[k] : tgt[k];
            if (goal[k] > act_w[k]) begin
                slew_next[k] = (goal[k] - act_w[k] > STEP) ? act_w[k] + STEP : goal[k];
            end else begin
                slew_next[k] = (act_w[k] - goal[k] > STEP) ? act_w[k] - STEP : goal[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                tgt[k]   <= CNT_W'(MID_CNT);
                act_w[k] <= CNT_W'(MID_CNT);
            end
            act_en <= '0;
        end else if (boundary) begin
            for (int k = 0; k < NUM_CH; k++) begin
                tgt[k]   <= goal[k];
                act_w[k] <= slew_next[k];
            end
            if (pending_o) begin
                act_en <= stg_en;
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < NUM_CH; k++) begin
                act_w[k] <= CNT_W'(MID_CNT);
            end
            act_en <= '0;
        end else if (boundary && pending_o) begin
            for (int k = 0; k < NUM_CH; k++) begin
                act_w[k] <= tgt_calc[k];
            end
            act_en <= stg_en;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            servo_pulse_o <= '0;
            frame_start_o <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                servo_pulse_o[k] <= act_en[k] && (cnt < act_w[k]);
            end
            frame_start_o <= boundary;
        end
    end

endmodule
